mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16, max consecutive loader grants under lock before a forced core turn.
REQ-002 Parameter AW, default 32, address and data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 core_req  input  1  core requests a memory access this cycle.
REQ-006 core_we  input  1  core access is a write.
REQ-007 core_adr, core_wd  input  AW each  core address and write data.
REQ-008 core_gnt  output  1  core access issued to memory this cycle.
REQ-009 core_stall  output  1  core_req & ~core_gnt; gates the core's PC/IR/register enables.
REQ-010 core_rvalid, core_rd  output  1, AW  core read data valid, one cycle after a core read grant.
REQ-011 ldr_req, ldr_we, ldr_lock  input  1 each  loader/debug request, write, and burst-lock hint.
REQ-012 ldr_adr, ldr_wd  input  AW each  loader address and write data.
REQ-013 ldr_gnt, ldr_rvalid, ldr_rd  output  1, 1, AW  loader grant, read valid, read data.
REQ-014 mem_adr, mem_wd, mem_we  output  AW, AW, 1  single-port unified memory command.
REQ-015 mem_rd  input  AW  memory read data, valid one cycle after the address is presented.

Function
REQ-016 At most one of core_gnt/ldr_gnt SHALL be high in any cycle.
REQ-017 Grants SHALL be combinational from the current requests and registered arbitration state.
REQ-018 A requester SHALL hold req, we, adr and wd stable until its grant is seen.
REQ-019 mem_adr/mem_wd SHALL mux the granted port; mem_we SHALL equal the granted port's we, else 0.
REQ-020 With no grant, mem_adr/mem_wd SHALL hold the core values and mem_we SHALL be 0.
REQ-021 Arbitration state SHALL be an FSM: RR (round-robin), LOCK (loader owns bus), YIELD (forced core turn).
REQ-022 RR, single requester: grant it.
REQ-023 RR, both requesting: grant the port opposite the last granted port; last-grant pointer updates on every grant.
REQ-024 RR -> LOCK when ldr_gnt & ldr_lock; burst counter loads 1.
REQ-025 LOCK: ldr_req grants loader unconditionally; counter increments per grant, saturating at MAX_BURST.
REQ-026 LOCK -> RR when ldr_lock falls or ldr_req falls; the core gets the next contention.
REQ-027 LOCK -> YIELD when counter = MAX_BURST and core_req is high; without core_req, LOCK persists.
REQ-028 YIELD: grant core for exactly one access, clear counter, -> RR with pointer = core.
REQ-029 A read grant SHALL register a 1-bit owner tag; next cycle the owner's rvalid = 1 and rd = mem_rd.
REQ-030 The non-owner's rvalid SHALL be 0, and its rd SHALL be 0.
REQ-031 Write grants SHALL produce no rvalid.
REQ-032 Back-to-back grants SHALL be supported: a read grant and the previous read's rvalid MAY coincide.

Reset
REQ-033 On reset low, state = RR, pointer = core, counter = 0, owner tag cleared.
REQ-034 While reset is low, all gnt/rvalid/mem_we outputs SHALL be 0.
REQ-035 A read in flight at reset SHALL be dropped: no rvalid after reset release.
REQ-036 The first cycle after reset release SHALL arbitrate normally.

Structure
REQ-037 Shared package arb_pkg SHALL hold the state encoding (RR/LOCK/YIELD), the port index constants (CORE = 0, LDR = 1), and the MAX_BURST default.
REQ-038 The burst counter SHALL be one sub-module, arb_burst_counter (load, increment, saturate, clear).
REQ-039 All other logic SHALL be flat in mem_arbiter.

Verification
REQ-040 Solo traffic: core read 0x40 at cycle 5, mem_rd = 0xE3A00005 -> core_gnt at cycle 5; core_rvalid with core_rd = 0xE3A00005 at cycle 6.
REQ-041 Contention: both request continuously, last grant = core -> grants alternate LDR, CORE, LDR, CORE; core_stall high on LDR cycles.
REQ-042 Lock burst, MAX_BURST = 16: ldr_lock and ldr_req high, core_req high -> exactly 16 ldr_gnt, then 1 core_gnt, then alternation.
REQ-043 Lock without core: 40 locked loader writes, core_req low -> 40 consecutive ldr_gnt, no YIELD; mem_we = 1 on each.
REQ-044 Reset mid-read: loader read granted at cycle 10, reset low at cycle 10.5 -> no ldr_rvalid, outputs 0, state RR.
REQ-045 Write then read: core write 0x123 to 0x80, then read 0x80 -> mem_we = 1 only on the write cycle; core_rvalid with 0x123 one cycle after the read grant.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the unified-memory arbiter: arbitration states,
// port indices and burst-length default.
`timescale 1ns/1ps
package arb_pkg;

    localparam int unsigned MAX_BURST_DEF = 16;

    typedef enum logic [1:0] {
        RR    = 2'd0,
        LOCK  = 2'd1,
        YIELD = 2'd2
    } arb_state_e;

    localparam logic CORE = 1'b0;
    localparam logic LDR  = 1'b1;

    // Counter width able to hold the value max_burst itself.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Counts consecutive locked loader grants; saturates at MAX_BURST and
// flags saturation so the arbiter can force a core turn.
`timescale 1ns/1ps
module arb_burst_counter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned     CW      = cnt_width(MAX_BURST);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BURST);

    logic [CW-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(1);
        end else if (inc && !sat) begin
            count <= count + CW'(1);
        end
    end

    assign sat = (count == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (core vs loader) in front of a single-port unified memory,
// with round-robin fairness, loader burst lock and forced core yield.
`timescale 1ns/1ps
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_adr,
    input  logic [AW-1:0] core_wd,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [AW-1:0] core_rd,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic          ldr_lock,
    input  logic [AW-1:0] ldr_adr,
    input  logic [AW-1:0] ldr_wd,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [AW-1:0] ldr_rd,
    output logic [AW-1:0] mem_adr,
    output logic [AW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [AW-1:0] mem_rd
);

    arb_state_e state, state_n;
    logic       last, last_n;
    logic       core_sel, ldr_sel;
    logic       cnt_load, cnt_inc, cnt_clr, burst_sat;
    logic       rd_pend, rd_owner;

    arb_burst_counter #(
        .MAX_BURST(MAX_BURST)
    ) u_burst (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .sat   (burst_sat)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        last_n   = last;
        core_sel = 1'b0;
        ldr_sel  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        case (state)
            RR: begin
                if (core_req && ldr_req) begin
                    ldr_sel  = (last == CORE);
                    core_sel = (last == LDR);
                end else begin
                    core_sel = core_req;
                    ldr_sel  = ldr_req;
                end
                if (ldr_sel && ldr_lock) begin
                    state_n  = LOCK;
                    cnt_load = 1'b1;
                end
            end
            LOCK: begin
                // A saturated burst with the core waiting leaves the bus idle one
                // cycle so the core gets exactly one turn in YIELD.
                if (burst_sat && core_req) begin
                    state_n = YIELD;
                end else if (ldr_req) begin
                    ldr_sel = 1'b1;
                    if (ldr_lock) begin
                        cnt_inc = 1'b1;
                    end else begin
                        state_n = RR;
                        cnt_clr = 1'b1;
                    end
                end else begin
                    core_sel = core_req;
                    state_n  = RR;
                    cnt_clr  = 1'b1;
                end
            end
            YIELD: begin
                core_sel = core_req;
                last_n   = CORE;
                cnt_clr  = 1'b1;
                state_n  = RR;
            end
            default: state_n = RR;
        endcase
        if (core_sel) begin
            last_n = CORE;
        end else if (ldr_sel) begin
            last_n = LDR;
        end
    end

    // Grants are combinational, so reset must mask them directly.
    assign core_gnt   = core_sel & reset;
    assign ldr_gnt    = ldr_sel & reset;
    assign core_stall = core_req & ~core_gnt;

    assign mem_adr = ldr_gnt ? ldr_adr : core_adr;
    assign mem_wd  = ldr_gnt ? ldr_wd  : core_wd;
    assign mem_we  = (core_gnt & core_we) | (ldr_gnt & ldr_we);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RR;
            last     <= CORE;
            rd_pend  <= 1'b0;
            rd_owner <= CORE;
        end else begin
            state   <= state_n;
            last    <= last_n;
            rd_pend <= (core_gnt & ~core_we) | (ldr_gnt & ~ldr_we);
            if (core_gnt || ldr_gnt) begin
                rd_owner <= ldr_gnt ? LDR : CORE;
            end
        end
    end

    assign core_rvalid = rd_pend & (rd_owner == CORE) & reset;
    assign ldr_rvalid  = rd_pend & (rd_owner == LDR) & reset;
    assign core_rd     = core_rvalid ? mem_rd : '0;
    assign ldr_rd      = ldr_rvalid ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port request drivers, a behavioural
// memory, and a negedge monitor comparing grants and read returns in order.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned MB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [AW-1:0] core_adr, core_wd, core_rd;
    logic          ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
    logic [AW-1:0] ldr_adr, ldr_wd, ldr_rd;
    logic [AW-1:0] mem_adr, mem_wd, mem_rd;
    logic          mem_we;

    typedef struct { logic we; logic lock; logic [31:0] adr; logic [31:0] wd; } op_t;
    typedef struct { logic port; logic we; logic [31:0] adr; logic [31:0] wd; } gnt_t;
    typedef struct { logic port; logic [31:0] data; } rd_t;

    op_t  core_q[$];
    op_t  ldr_q[$];
    gnt_t exp_g[$];
    rd_t  exp_r[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    mem_arbiter #(.MAX_BURST(MB), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wd(core_wd),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rd(core_rd),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_adr(ldr_adr), .ldr_wd(ldr_wd),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rd(ldr_rd),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Preloaded read-only contents overlaid by anything written during the run.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h40:  return 32'hE3A0_0005;
            32'h44:  return 32'h1111_1111;
            32'h48:  return 32'h2222_2222;
            32'h200: return 32'hAAAA_0001;
            32'h204: return 32'hAAAA_0002;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] wmem   [0:1023];
    logic        wvalid [0:1023] = '{default: 1'b0};

    always @(posedge clk) begin
        if (mem_we) begin
            wmem[mem_adr[11:2]]   <= mem_wd;
            wvalid[mem_adr[11:2]] <= 1'b1;
        end
        mem_rd <= wvalid[mem_adr[11:2]] ? wmem[mem_adr[11:2]] : rom(mem_adr);
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic add_op(input logic port, input logic we, input logic lock,
                          input logic [31:0] adr, input logic [31:0] wd);
        op_t o;
        o.we = we; o.lock = lock; o.adr = adr; o.wd = wd;
        if (port == LDR) ldr_q.push_back(o);
        else             core_q.push_back(o);
    endtask

    task automatic exp_grant(input logic port, input logic we,
                             input logic [31:0] adr, input logic [31:0] wd);
        gnt_t g;
        g.port = port; g.we = we; g.adr = adr; g.wd = wd;
        exp_g.push_back(g);
    endtask

    task automatic exp_read(input logic port, input logic [31:0] data);
        rd_t r;
        r.port = port; r.data = data;
        exp_r.push_back(r);
    endtask

    // Requesters hold their request until a grant is seen, then move to the next op.
    initial begin : core_drv
        op_t  op;
        logic g;
        core_req = 1'b0; core_we = 1'b0; core_adr = '0; core_wd = '0;
        forever begin
            if (core_q.size() != 0) begin
                op = core_q[0];
                core_req = 1'b1; core_we = op.we; core_adr = op.adr; core_wd = op.wd;
            end else begin
                core_req = 1'b0; core_we = 1'b0;
            end
            @(negedge clk);
            g = core_gnt;
            @(posedge clk);
            #1;
            if (g && core_req) void'(core_q.pop_front());
        end
    end

    initial begin : ldr_drv
        op_t  op;
        logic g;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0; ldr_adr = '0; ldr_wd = '0;
        forever begin
            if (ldr_q.size() != 0) begin
                op = ldr_q[0];
                ldr_req = 1'b1; ldr_we = op.we; ldr_lock = op.lock; ldr_adr = op.adr; ldr_wd = op.wd;
            end else begin
                ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0;
            end
            @(negedge clk);
            g = ldr_gnt;
            @(posedge clk);
            #1;
            if (g && ldr_req) void'(ldr_q.pop_front());
        end
    end

    always @(negedge clk) begin : monitor
        gnt_t eg;
        rd_t  er;
        logic port;
        logic prev_rd_v;
        logic prev_rd_port;
        if (!reset) begin
            prev_rd_v = 1'b0;
        end else begin
            check("gnt_exclusive", 32'(core_gnt & ldr_gnt), 0);
            check("core_stall", 32'(core_stall), 32'(core_req & ~core_gnt));
            if (core_gnt || ldr_gnt) begin
                check("grant_expected", 32'(exp_g.size() != 0), 1);
                if (exp_g.size() != 0) begin
                    eg = exp_g.pop_front();
                    check("grant_port", 32'(ldr_gnt), 32'(eg.port));
                    check("mem_we", 32'(mem_we), 32'(eg.we));
                    check("mem_adr", mem_adr, eg.adr);
                    if (eg.we) check("mem_wd", mem_wd, eg.wd);
                end
            end else begin
                check("idle_mem_we", 32'(mem_we), 0);
                check("idle_mem_adr", mem_adr, core_adr);
            end
            check("rvalid_exclusive", 32'(core_rvalid & ldr_rvalid), 0);
            if (core_rvalid || ldr_rvalid) begin
                port = ldr_rvalid;
                check("rvalid_expected", 32'(exp_r.size() != 0), 1);
                if (exp_r.size() != 0) begin
                    er = exp_r.pop_front();
                    check("rvalid_port", 32'(port), 32'(er.port));
                    check("rd_data", port ? ldr_rd : core_rd, er.data);
                end
                check("nonowner_rd", port ? core_rd : ldr_rd, 0);
                check("rvalid_latency", 32'(prev_rd_v && (prev_rd_port == port)), 1);
            end
            prev_rd_v    = (core_gnt & ~core_we) | (ldr_gnt & ~ldr_we);
            prev_rd_port = ldr_gnt;
        end
    end

    task automatic drain(input string name);
        int t = 0;
        while ((core_q.size() != 0 || ldr_q.size() != 0 || exp_g.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({name, "_ops_left"}, 32'(core_q.size() + ldr_q.size()), 0);
        check({name, "_grants_left"}, 32'(exp_g.size()), 0);
        check({name, "_reads_left"}, 32'(exp_r.size()), 0);
        core_q.delete(); ldr_q.delete(); exp_g.delete(); exp_r.delete();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_core_gnt"}, 32'(core_gnt), 0);
        check({name, "_ldr_gnt"}, 32'(ldr_gnt), 0);
        check({name, "_core_rvalid"}, 32'(core_rvalid), 0);
        check({name, "_ldr_rvalid"}, 32'(ldr_rvalid), 0);
        check({name, "_mem_we"}, 32'(mem_we), 0);
    endtask

    initial begin : watchdog
        #100us;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_quiet("after_release");
        check("after_release_mem_adr", mem_adr, 32'h0);

        // Solo core read: request driven during cycle 5, data back in cycle 6.
        while (cyc < 4) @(negedge clk);
        exp_grant(CORE, 1'b0, 32'h40, 32'h0);
        exp_read(CORE, 32'hE3A0_0005);
        add_op(CORE, 1'b0, 1'b0, 32'h40, 32'h0);
        while (cyc < 5) @(negedge clk);
        check("solo_gnt_cycle5", 32'(core_gnt), 1);
        check("solo_mem_adr", mem_adr, 32'h40);
        @(negedge clk);
        check("solo_rvalid_cycle6", 32'(core_rvalid), 1);
        check("solo_rd", core_rd, 32'hE3A0_0005);
        drain("solo");

        // Contention after a core grant: LDR, CORE, LDR, CORE, reads back to back.
        exp_grant(LDR, 1'b0, 32'h200, 32'h0);
        exp_grant(CORE, 1'b0, 32'h44, 32'h0);
        exp_grant(LDR, 1'b0, 32'h204, 32'h0);
        exp_grant(CORE, 1'b0, 32'h48, 32'h0);
        exp_read(LDR, 32'hAAAA_0001);
        exp_read(CORE, 32'h1111_1111);
        exp_read(LDR, 32'hAAAA_0002);
        exp_read(CORE, 32'h2222_2222);
        add_op(LDR, 1'b0, 1'b0, 32'h200, 32'h0);
        add_op(LDR, 1'b0, 1'b0, 32'h204, 32'h0);
        add_op(CORE, 1'b0, 1'b0, 32'h44, 32'h0);
        add_op(CORE, 1'b0, 1'b0, 32'h48, 32'h0);
        drain("contend");

        // Locked burst with the core waiting: 16 loader grants, one core turn, then alternation.
        for (int i = 0; i < int'(MB); i++) begin
            exp_grant(LDR, 1'b1, 32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i));
            add_op(LDR, 1'b1, 1'b1, 32'h300 + 32'(4 * i), 32'hB000_0000 + 32'(i));
        end
        exp_grant(CORE, 1'b0, 32'h40, 32'h0);
        exp_grant(LDR, 1'b1, 32'h340, 32'hB000_0010);
        exp_grant(CORE, 1'b0, 32'h44, 32'h0);
        exp_grant(LDR, 1'b1, 32'h344, 32'hB000_0011);
        exp_grant(CORE, 1'b0, 32'h48, 32'h0);
        exp_read(CORE, 32'hE3A0_0005);
        exp_read(CORE, 32'h1111_1111);
        exp_read(CORE, 32'h2222_2222);
        add_op(LDR, 1'b1, 1'b0, 32'h340, 32'hB000_0010);
        add_op(LDR, 1'b1, 1'b0, 32'h344, 32'hB000_0011);
        add_op(CORE, 1'b0, 1'b0, 32'h40, 32'h0);
        add_op(CORE, 1'b0, 1'b0, 32'h44, 32'h0);
        add_op(CORE, 1'b0, 1'b0, 32'h48, 32'h0);
        drain("burst");

        // Locked writes with no core traffic: 40 grants in consecutive cycles.
        for (int i = 0; i < 40; i++) begin
            exp_grant(LDR, 1'b1, 32'h600 + 32'(4 * i), 32'hC000_0000 + 32'(i));
            add_op(LDR, 1'b1, 1'b1, 32'h600 + 32'(4 * i), 32'hC000_0000 + 32'(i));
        end
        t = 0;
        while (!ldr_gnt && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 40; i++) begin
            check($sformatf("lock_stream_%0d", i), 32'(ldr_gnt), 1);
            @(negedge clk);
        end
        check("lock_stream_end", 32'(ldr_gnt), 0);
        drain("lock40");

        // Write then read of the same word.
        exp_grant(CORE, 1'b1, 32'h80, 32'h123);
        exp_grant(CORE, 1'b0, 32'h80, 32'h0);
        exp_read(CORE, 32'h123);
        add_op(CORE, 1'b1, 1'b0, 32'h80, 32'h123);
        add_op(CORE, 1'b0, 1'b0, 32'h80, 32'h0);
        drain("wr_rd");

        // Reset half a cycle after a loader read grant: the read must never return.
        exp_grant(LDR, 1'b0, 32'h204, 32'h0);
        add_op(LDR, 1'b0, 1'b0, 32'h204, 32'h0);
        t = 0;
        while (!ldr_gnt && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rst_read_granted", 32'(ldr_gnt), 1);
        #1 reset = 1'b0;
        add_op(CORE, 1'b1, 1'b0, 32'h84, 32'h55);
        add_op(LDR, 1'b1, 1'b0, 32'h208, 32'h66);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet($sformatf("rst_hold_%0d", i));
        end
        exp_grant(LDR, 1'b1, 32'h208, 32'h66);
        exp_grant(CORE, 1'b1, 32'h84, 32'h55);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_first_cycle_ldr_gnt", 32'(ldr_gnt), 1);
        check("rst_no_ldr_rvalid", 32'(ldr_rvalid), 0);
        drain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
